// File: rtl/dsp_pkg.sv
// Shared DSP audio definitions: pass-control state encoding and the default
// RAM/channel/frame widths used by both the frame writer and the sequencer.
package dsp_pkg;

  localparam int unsigned DEF_CHAN_W  = 4;
  localparam int unsigned DEF_FRAME_W = 4;
  localparam int unsigned DEF_AUDIO_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/frame_chan_counter.sv
// Tracks the expected channel within a frame and the circular write frame index.
// Resyncs to the received channel so one bad tag does not misalign the whole frame.
module frame_chan_counter
  import dsp_pkg::*;
#(
  parameter int unsigned CHAN_W  = DEF_CHAN_W,
  parameter int unsigned FRAME_W = DEF_FRAME_W,
  parameter int unsigned NCHAN   = 16
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               accept,
  input  logic [CHAN_W-1:0]  in_chan,
  output logic [CHAN_W-1:0]  exp_chan,
  output logic [FRAME_W-1:0] wr_frame,
  output logic               frame_done
);

  localparam logic [CHAN_W-1:0] LastChan = CHAN_W'(NCHAN - 1);

  logic [CHAN_W-1:0]  exp_chan_q, exp_chan_d;
  logic [FRAME_W-1:0] wr_frame_q, wr_frame_d;

  assign frame_done = accept && (in_chan == LastChan);

  always_comb begin
    exp_chan_d = exp_chan_q;
    wr_frame_d = wr_frame_q;
    if (accept) begin
      exp_chan_d = frame_done ? '0 : in_chan + CHAN_W'(1);
    end
    // Natural FRAME_W-bit overflow gives the circular wrap.
    if (frame_done) begin
      wr_frame_d = wr_frame_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      exp_chan_q <= '0;
      wr_frame_q <= '0;
    end else begin
      exp_chan_q <= exp_chan_d;
      wr_frame_q <= wr_frame_d;
    end
  end

  assign exp_chan = exp_chan_q;
  assign wr_frame = wr_frame_q;

endmodule

// File: rtl/audio_frame_writer.sv
// Writes tagged input samples into the circular audio RAM and, per completed frame,
// runs one sequencer pass (run / done / one-cycle flush) with a single pending slot.
module audio_frame_writer
  import dsp_pkg::*;
#(
  parameter int unsigned CHAN_W  = DEF_CHAN_W,
  parameter int unsigned FRAME_W = DEF_FRAME_W,
  parameter int unsigned AUDIO_W = DEF_AUDIO_W,
  parameter int unsigned NCHAN   = 16
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [CHAN_W-1:0]  in_chan,
  input  logic [15:0]        in_data,
  output logic               in_ready,
  output logic               audio_we,
  output logic [AUDIO_W-1:0] audio_waddr,
  output logic [15:0]        audio_wdata,
  output logic [FRAME_W-1:0] frame,
  output logic               seq_run,
  input  logic               seq_done,
  output logic               late,
  output logic               error
);

  localparam logic [CHAN_W-1:0] LastChan = CHAN_W'(NCHAN - 1);

  logic [CHAN_W-1:0]  exp_chan;
  logic [FRAME_W-1:0] wr_frame;
  logic               frame_done;
  logic               accept;

  logic               we_q;
  logic [AUDIO_W-1:0] waddr_q;
  logic [15:0]        wdata_q;

  // Frame completion is acted on when its last write lands, not when it is accepted.
  logic               done_q;
  logic [FRAME_W-1:0] done_frame_q;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               pending_q, pending_d;
  logic [FRAME_W-1:0] pend_frame_q, pend_frame_d;
  logic               late_q, late_d;
  logic               error_q;

  // Holding the last channel while a frame is already pending stops a third completion.
  assign in_ready = !(pending_q && (exp_chan == LastChan));
  assign accept   = in_valid && in_ready;

  frame_chan_counter #(
    .CHAN_W  (CHAN_W),
    .FRAME_W (FRAME_W),
    .NCHAN   (NCHAN)
  ) u_counter (
    .ck         (ck),
    .rst        (rst),
    .accept     (accept),
    .in_chan    (in_chan),
    .exp_chan   (exp_chan),
    .wr_frame   (wr_frame),
    .frame_done (frame_done)
  );

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      done_frame_q <= '0;
      error_q      <= 1'b0;
    end else begin
      we_q   <= accept;
      done_q <= frame_done;
      if (accept) begin
        waddr_q <= AUDIO_W'({wr_frame, in_chan});
        wdata_q <= in_data;
        if (in_chan != exp_chan) begin
          error_q <= 1'b1;
        end
      end
      if (frame_done) begin
        done_frame_q <= wr_frame;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    pending_d    = pending_q;
    pend_frame_d = pend_frame_q;
    late_d       = late_q;
    unique case (state_q)
      ST_IDLE: begin
        // A frame parked during the last flush is launched before anything new.
        if (pending_q) begin
          frame_d   = pend_frame_q;
          pending_d = 1'b0;
          state_d   = ST_RUN;
        end else if (done_q) begin
          frame_d = done_frame_q;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (seq_done) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (pending_q) begin
          frame_d   = pend_frame_q;
          pending_d = 1'b0;
          state_d   = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Applied last so a completion in the same cycle as a pending launch re-fills the slot.
    if (done_q && ((state_q != ST_IDLE) || pending_q)) begin
      pend_frame_d = done_frame_q;
      pending_d    = 1'b1;
      late_d       = (state_q != ST_IDLE) ? 1'b1 : late_q;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      pending_q    <= 1'b0;
      pend_frame_q <= '0;
      late_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      pending_q    <= pending_d;
      pend_frame_q <= pend_frame_d;
      late_q       <= late_d;
    end
  end

  assign audio_we    = we_q;
  assign audio_waddr = waddr_q;
  assign audio_wdata = wdata_q;
  assign frame       = frame_q;
  assign seq_run     = (state_q == ST_RUN);
  assign late        = late_q;
  assign error       = error_q;

endmodule

// File: tb/tb_audio_frame_writer.sv
// Directed bench for audio_frame_writer: writes, pass sequencing, pending/late,
// frame wrap, channel resync and mid-pass reset.
module tb_audio_frame_writer;

  logic        ck = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_chan;
  logic [15:0] in_data;
  logic        in_ready;
  logic        audio_we;
  logic [8:0]  audio_waddr;
  logic [15:0] audio_wdata;
  logic [3:0]  frame;
  logic        seq_run;
  logic        seq_done;
  logic        late;
  logic        error;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [3:0]  m_wr     = 4'd0;

  localparam logic [31:0] Idle  = 32'd0;
  localparam logic [31:0] Run   = 32'd1;
  localparam logic [31:0] Flush = 32'd2;

  audio_frame_writer dut (
    .ck          (ck),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_chan     (in_chan),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .audio_we    (audio_we),
    .audio_waddr (audio_waddr),
    .audio_wdata (audio_wdata),
    .frame       (frame),
    .seq_run     (seq_run),
    .seq_done    (seq_done),
    .late        (late),
    .error       (error)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // Presents one sample, waits (bounded) for ready, and checks the resulting write.
  task automatic send(input logic [3:0] c, input logic [15:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_chan  = c;
    in_data  = d;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    check("ready_timeout", 32'(t < 50), 32'd1);
    step();
    in_valid = 1'b0;
    check("we", 32'(audio_we), 32'd1);
    check("waddr", 32'(audio_waddr), {23'd0, 1'b0, m_wr, c});
    check("wdata", 32'(audio_wdata), 32'(d));
    if (c == 4'd15) m_wr = m_wr + 4'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_chan  = '0;
    in_data  = '0;
    seq_done = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    // Reset state
    check("rst_we", 32'(audio_we), 0);
    check("rst_waddr", 32'(audio_waddr), 0);
    check("rst_frame", 32'(frame), 0);
    check("rst_run", 32'(seq_run), 0);
    check("rst_late", 32'(late), 0);
    check("rst_error", 32'(error), 0);
    check("rst_ready", 32'(in_ready), 1);
    rst = 1'b1;

    // 1: first frame, pass starts one cycle after the last write
    for (int c = 0; c < 16; c++) send(4'(c), 16'h0100 + 16'(c));
    check("t1_run_early", 32'(seq_run), 0);
    step();
    check("t1_run", 32'(seq_run), 1);
    check("t1_we_off", 32'(audio_we), 0);
    check("t1_frame", 32'(frame), 0);
    check("t1_hold_addr", 32'(audio_waddr), 32'h00F);

    // 2: done pulse -> one flush cycle -> idle
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    check("t2_flush_run", 32'(seq_run), 0);
    check("t2_flush_st", 32'(dut.state_q), Flush);
    step();
    check("t2_idle_st", 32'(dut.state_q), Idle);
    check("t2_idle_run", 32'(seq_run), 0);
    check("t2_late", 32'(late), 0);
    check("t2_error", 32'(error), 0);

    // 3: overlapping frames while the pass is held
    for (int c = 0; c < 16; c++) send(4'(c), 16'h1100 + 16'(c));
    step();
    check("t3_run", 32'(seq_run), 1);
    check("t3_frame1", 32'(frame), 1);
    for (int c = 0; c < 16; c++) send(4'(c), 16'h1200 + 16'(c));
    step();
    check("t3_pending", 32'(dut.pending_q), 1);
    check("t3_pend_frame", 32'(dut.pend_frame_q), 2);
    check("t3_late", 32'(late), 1);
    check("t3_frame_kept", 32'(frame), 1);
    for (int c = 0; c < 15; c++) send(4'(c), 16'h1300 + 16'(c));
    in_valid = 1'b1;
    in_chan  = 4'd15;
    in_data  = 16'h130F;
    #1;
    check("t3_backpressure", 32'(in_ready), 0);
    step();
    check("t3_no_write", 32'(audio_we), 0);
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    check("t3_flush_st", 32'(dut.state_q), Flush);
    check("t3_flush_run", 32'(seq_run), 0);
    check("t3_flush_ready", 32'(in_ready), 0);
    step();
    check("t3_relaunch_run", 32'(seq_run), 1);
    check("t3_relaunch_frame", 32'(frame), 2);
    check("t3_pend_clear", 32'(dut.pending_q), 0);
    check("t3_ready_back", 32'(in_ready), 1);
    check("t3_still_held", 32'(audio_we), 0);
    step();
    in_valid = 1'b0;
    check("t3_late_write_we", 32'(audio_we), 1);
    check("t3_late_write_addr", 32'(audio_waddr), 32'h03F);
    m_wr = m_wr + 4'd1;
    step();
    check("t3_pend3", 32'(dut.pend_frame_q), 3);
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    step();
    check("t3_frame3", 32'(frame), 3);
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    step();
    check("t3_idle", 32'(dut.state_q), Idle);

    // 4: sixteen frames, wrapping 15 -> 0 (address check lives in send)
    seq_done = 1'b1;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) send(4'(c), 16'(f * 16 + c));
    end
    repeat (4) step();
    seq_done = 1'b0;
    check("t4_model_wr", 32'(m_wr), 4);
    check("t4_idle", 32'(dut.state_q), Idle);
    check("t4_frame", 32'(frame), 3);
    check("t4_no_pend", 32'(dut.pending_q), 0);
    check("t4_error", 32'(error), 0);

    // 5: channel skip -> error, resync to 6
    send(4'd0, 16'hA000);
    send(4'd1, 16'hA001);
    check("t5_no_error", 32'(error), 0);
    send(4'd5, 16'hA005);
    check("t5_error", 32'(error), 1);
    check("t5_addr", 32'(audio_waddr), 32'h045);
    check("t5_exp6", 32'(dut.u_counter.exp_chan_q), 6);
    for (int c = 6; c < 16; c++) send(4'(c), 16'hA000 + 16'(c));
    step();
    check("t5_run", 32'(seq_run), 1);
    check("t5_frame", 32'(frame), 4);

    // 6: reset in the middle of a pass and a partial frame
    for (int c = 0; c < 4; c++) send(4'(c), 16'hB000 + 16'(c));
    rst = 1'b0;
    #1;
    check("t6_run", 32'(seq_run), 0);
    check("t6_we", 32'(audio_we), 0);
    check("t6_late", 32'(late), 0);
    check("t6_error", 32'(error), 0);
    check("t6_frame", 32'(frame), 0);
    m_wr = 4'd0;
    #3;
    rst = 1'b1;
    step();
    send(4'd0, 16'hC000);
    send(4'd1, 16'hC001);
    check("t6_addr1", 32'(audio_waddr), 32'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
